// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [DEF_INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        S_FETCH,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; flush beats push.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop_ok;
    logic         push_ok;

    // Pop needs data; push needs room, where a same-cycle pop frees the slot.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, halt/redirect control and the fetch buffer.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_FETCH | addressing imem at pc, pushing words while buffer has room
// S_HALT  | HALT word buffered; pc frozen, buffer drains, no pushes
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               halted
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic            room;

    assign imem_addr = pc_q;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign halted    = (state_q == S_HALT);

    // id_ready feeds push only through room, so a full buffer refills on pop.
    assign pop        = if_valid && id_ready;
    assign room       = (count != 2'd2) || pop;
    assign push       = (state_q == S_FETCH) && !redirect_valid && room;
    assign push_entry = '{pc: pc_q, instr: imem_data};

    // Next-state and next-pc: redirect first, then a push advances pc.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
            pc_d    = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + 1'b1;
            if (imem_data == HALT_INSTR) begin
                state_d = S_HALT;
            end
        end
    end

    // State and pc registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        halted;

    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered queue of {pc, instr}, a pc and a halt flag.
    logic [23:0] m_q [$];
    logic [7:0]  m_pc;
    logic        m_halt;
    logic        m_live = 1'b0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: consumer takes the head first, then fetch refills.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc   = 8'h00;
            m_halt = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (redirect_valid) begin
                m_q.delete();
                m_pc   = redirect_pc;
                m_halt = 1'b0;
            end else begin
                if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                if (!m_halt && m_q.size() < 2) begin
                    m_q.push_back({m_pc, mem[m_pc]});
                    if (mem[m_pc] == 16'hFFFF) m_halt = 1'b1;
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_valid", 32'(if_valid), 32'(m_q.size() > 0));
            chk("m_halted", 32'(halted), 32'(m_halt));
            chk("m_addr", 32'(imem_addr), 32'(m_pc));
            if (m_q.size() > 0) begin
                chk("m_pc", 32'(if_pc), 32'(m_q[0][23:16]));
                chk("m_instr", 32'(if_instr), 32'(m_q[0][15:0]));
            end
        end
    end

    initial begin
        logic [7:0] e;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst_n = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;

        // Reset values, then streaming at full rate.
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_instr", 32'(if_instr), 32'h0);
        chk("rst_pc", 32'(if_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(if_valid), 32'h1);
            chk("stream_pc", 32'(if_pc), 32'(k));
            chk("stream_instr", 32'(if_instr), 32'h1000 + 32'(k));
        end

        // Stall from reset: buffer fills to two, pc stops at 2.
        rst_n = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_addr", 32'(imem_addr), 32'h02);
        chk("stall_pc", 32'(if_pc), 32'h00);
        chk("stall_valid", 32'(if_valid), 32'h1);
        id_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("release_pc", 32'(if_pc), 32'(k));
        end

        // Redirect out of a full, stalled buffer.
        @(negedge clk);
        @(negedge clk);
        chk("full_pc5", 32'(if_pc), 32'h05);
        id_ready = 1'b0;
        @(negedge clk);
        chk("full_hold", 32'(if_pc), 32'h05);
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(if_valid), 32'h0);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        @(negedge clk);
        chk("redir_pc", 32'(if_pc), 32'h40);
        chk("redir_instr", 32'(if_instr), 32'h1040);

        // Redirect near the top of the address space; pc wraps.
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = 8'hFE + 8'(k);
            chk("wrap_pc", 32'(if_pc), 32'(e));
        end

        // HALT at address 3.
        mem[3] = 16'hFFFF;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_seq_pc", 32'(if_pc), 32'(k));
        end
        chk("halt_word", 32'(if_instr), 32'hFFFF);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_addr", 32'(imem_addr), 32'h04);
        repeat (3) begin
            @(negedge clk);
            chk("halt_novalid", 32'(if_valid), 32'h0);
            chk("halt_frozen", 32'(imem_addr), 32'h04);
        end
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("unhalt_flag", 32'(halted), 32'h0);
        @(negedge clk);
        chk("unhalt_pc", 32'(if_pc), 32'h10);

        // Full buffer in S_HALT, then a one-cycle reset.
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h02;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fullhalt_flag", 32'(halted), 32'h1);
        chk("fullhalt_pc", 32'(if_pc), 32'h02);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_valid", 32'(if_valid), 32'h0);
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_addr", 32'(imem_addr), 32'h00);
        chk("rst2_pc", 32'(if_pc), 32'h00);
        chk("rst2_instr", 32'(if_instr), 32'h0);
        id_ready = 1'b1;
        @(negedge clk);
        chk("restart_pc", 32'(if_pc), 32'h00);
        chk("restart_instr", 32'(if_instr), 32'h1000);

        // Random program with scattered HALTs, random stalls/redirects/resets.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 249) != 0);
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc = 8'($urandom);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
